// File: rtl/pin_scanner.sv
// pin_scanner: one-hot scanner for the Arduino-facing pin bank.
// Drives one unmasked pin at a time in ascending order. Each pin is held
// for dwell+1 cycles and followed by a single all-low gap cycle. Runs
// continuously, or for one frame per start pulse when one_shot=1.
module pin_scanner #(
  parameter int NUM_PINS = 6,
  parameter int IDX_W    = 3,
  parameter int DWELL_W  = 8
) (
  input  logic                arduino_clk,
  input  logic                arduino_rst_n,
  input  logic                enable,
  input  logic                one_shot,
  input  logic                start,
  input  logic [DWELL_W-1:0]  dwell,
  input  logic [NUM_PINS-1:0] skip_mask,
  output logic [NUM_PINS-1:0] pins,
  output logic [IDX_W-1:0]    pin_idx,
  output logic                pin_valid,
  output logic                frame_done,
  output logic                busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [NUM_PINS-1:0] PIN_ONE = NUM_PINS'(1);

  state_t             state;
  logic [DWELL_W-1:0] dwell_cnt;

  logic               first_found;
  logic [IDX_W-1:0]   first_idx;
  logic               next_found;
  logic [IDX_W-1:0]   next_idx;

  // Lowest unmasked pin, scanning downwards so the lowest index wins last.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    for (int i = NUM_PINS - 1; i >= 0; i--) begin
      if (!skip_mask[i]) begin
        first_found = 1'b1;
        first_idx   = IDX_W'(i);
      end
    end
  end

  // Lowest unmasked pin strictly above the one currently held in pin_idx.
  always_comb begin
    next_found = 1'b0;
    next_idx   = '0;
    for (int i = NUM_PINS - 1; i >= 0; i--) begin
      if (!skip_mask[i] && (i > int'(pin_idx))) begin
        next_found = 1'b1;
        next_idx   = IDX_W'(i);
      end
    end
  end

  // Scanner FSM with every output registered alongside the state.
  // frame_done is decided on the way into GAP, so it marks the gap that
  // follows the last unmasked pin of the frame.
  always_ff @(posedge arduino_clk or negedge arduino_rst_n) begin
    if (!arduino_rst_n) begin
      state      <= ST_IDLE;
      pins       <= '0;
      pin_idx    <= '0;
      pin_valid  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      dwell_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable && (!one_shot || start) && first_found) begin
            state     <= ST_DRIVE;
            pin_idx   <= first_idx;
            pins      <= PIN_ONE << first_idx;
            pin_valid <= 1'b1;
            busy      <= 1'b1;
            dwell_cnt <= dwell;
          end
        end

        ST_DRIVE: begin
          if (!enable) begin
            state     <= ST_IDLE;
            pins      <= '0;
            pin_idx   <= '0;
            pin_valid <= 1'b0;
            busy      <= 1'b0;
            dwell_cnt <= '0;
          end else if (dwell_cnt == '0) begin
            state      <= ST_GAP;
            pins       <= '0;
            pin_valid  <= 1'b0;
            frame_done <= !next_found;
          end else begin
            dwell_cnt <= dwell_cnt - 1'b1;
          end
        end

        ST_GAP: begin
          if (!enable) begin
            state     <= ST_IDLE;
            pin_idx   <= '0;
            busy      <= 1'b0;
            dwell_cnt <= '0;
          end else if (!frame_done && next_found) begin
            state     <= ST_DRIVE;
            pin_idx   <= next_idx;
            pins      <= PIN_ONE << next_idx;
            pin_valid <= 1'b1;
            dwell_cnt <= dwell;
          end else if (!one_shot && first_found) begin
            state     <= ST_DRIVE;
            pin_idx   <= first_idx;
            pins      <= PIN_ONE << first_idx;
            pin_valid <= 1'b1;
            dwell_cnt <= dwell;
          end else begin
            state     <= ST_IDLE;
            pin_idx   <= '0;
            busy      <= 1'b0;
            dwell_cnt <= '0;
          end
        end

        default: begin
          state     <= ST_IDLE;
          pins      <= '0;
          pin_idx   <= '0;
          pin_valid <= 1'b0;
          busy      <= 1'b0;
          dwell_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pin_scanner.sv
// tb_pin_scanner: directed self-checking bench for pin_scanner.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pin_scanner;

  localparam int NUM_PINS = 6;
  localparam int IDX_W    = 3;
  localparam int DWELL_W  = 8;

  logic                arduino_clk   = 1'b0;
  logic                arduino_rst_n = 1'b0;
  logic                enable        = 1'b0;
  logic                one_shot      = 1'b0;
  logic                start         = 1'b0;
  logic [DWELL_W-1:0]  dwell         = '0;
  logic [NUM_PINS-1:0] skip_mask     = '0;
  logic [NUM_PINS-1:0] pins;
  logic [IDX_W-1:0]    pin_idx;
  logic                pin_valid;
  logic                frame_done;
  logic                busy;

  int check_count = 0;
  int fail_count  = 0;

  pin_scanner #(
    .NUM_PINS (NUM_PINS),
    .IDX_W    (IDX_W),
    .DWELL_W  (DWELL_W)
  ) dut (
    .arduino_clk   (arduino_clk),
    .arduino_rst_n (arduino_rst_n),
    .enable        (enable),
    .one_shot      (one_shot),
    .start         (start),
    .dwell         (dwell),
    .skip_mask     (skip_mask),
    .pins          (pins),
    .pin_idx       (pin_idx),
    .pin_valid     (pin_valid),
    .frame_done    (frame_done),
    .busy          (busy)
  );

  // Free-running 10 ns clock.
  always #5 arduino_clk = ~arduino_clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input int exp_pins, input int exp_idx,
                          input int exp_fd, input int exp_busy);
    checkOutput({tag, ".pins"}, 32'(pins), 32'(exp_pins));
    checkOutput({tag, ".idx"}, 32'(pin_idx), 32'(exp_idx));
    checkOutput({tag, ".valid"}, 32'(pin_valid), (exp_pins != 0) ? 32'd1 : 32'd0);
    checkOutput({tag, ".fd"}, 32'(frame_done), 32'(exp_fd));
    checkOutput({tag, ".busy"}, 32'(busy), 32'(exp_busy));
  endtask

  task automatic applyStimulus(input logic en, input logic os, input int dw,
                               input logic [NUM_PINS-1:0] mask);
    enable    = en;
    one_shot  = os;
    dwell     = DWELL_W'(dw);
    skip_mask = mask;
  endtask

  // Reset for one cycle with the new inputs applied, release on a falling edge.
  task automatic doReset(input logic en, input logic os, input int dw,
                         input logic [NUM_PINS-1:0] mask);
    @(negedge arduino_clk);
    arduino_rst_n = 1'b0;
    start = 1'b0;
    applyStimulus(en, os, dw, mask);
    @(negedge arduino_clk);
    arduino_rst_n = 1'b1;
  endtask

  initial begin
    int seq_pins[13];
    int seq_idx[13];
    int fd_total;

    $display("[TB] pin_scanner bench start");

    // Reset state
    repeat (3) @(negedge arduino_clk);
    checkAll("reset", 0, 0, 0, 0);

    // Continuous full scan, dwell=0, then continue to pin 3
    applyStimulus(1'b1, 1'b0, 0, 6'b000000);
    arduino_rst_n = 1'b1;
    for (int k = 0; k <= 18; k++) begin
      @(negedge arduino_clk);
      checkAll($sformatf("scan%0d", k),
               (k % 2 == 0) ? (1 << ((k / 2) % 6)) : 0,
               (k / 2) % 6, (k == 11) ? 1 : 0, 1);
    end

    // Asynchronous reset while pin 3 is driven
    #2 arduino_rst_n = 1'b0;
    #1;
    checkOutput("async_rst.pins", 32'(pins), 32'd0);
    checkOutput("async_rst.busy", 32'(busy), 32'd0);
    checkOutput("async_rst.idx", 32'(pin_idx), 32'd0);
    @(negedge arduino_clk);
    arduino_rst_n = 1'b1;
    @(negedge arduino_clk);
    checkAll("after_rst", 1, 0, 0, 1);

    // Dwell and mask: pins 0, 3, 5 for 3 cycles each
    seq_pins = '{1, 1, 1, 0, 8, 8, 8, 0, 32, 32, 32, 0, 1};
    seq_idx  = '{0, 0, 0, 0, 3, 3, 3, 3, 5, 5, 5, 5, 0};
    doReset(1'b1, 1'b0, 2, 6'b010110);
    for (int k = 0; k < 13; k++) begin
      @(negedge arduino_clk);
      checkAll($sformatf("mask%0d", k), seq_pins[k], seq_idx[k], (k == 11) ? 1 : 0, 1);
      if (k == 1) dwell = DWELL_W'(7);
      if (k == 3) dwell = DWELL_W'(2);
    end

    // One-shot frame with a start pulse mid-frame that must be ignored
    doReset(1'b1, 1'b1, 1, 6'b000000);
    repeat (3) begin
      @(negedge arduino_clk);
      checkAll("os_idle", 0, 0, 0, 0);
    end
    start = 1'b1;
    fd_total = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge arduino_clk);
      start = (k == 5) ? 1'b1 : 1'b0;
      if (frame_done) fd_total++;
      if (k < 18)
        checkAll($sformatf("os%0d", k), (k % 3 != 2) ? (1 << (k / 3)) : 0,
                 k / 3, (k == 17) ? 1 : 0, 1);
      else
        checkAll($sformatf("os%0d", k), 0, 0, 0, 0);
    end
    checkOutput("os_fd_count", 32'(fd_total), 32'd1);

    // Abort while pin 2 is driven, then re-enable
    doReset(1'b1, 1'b0, 0, 6'b000000);
    for (int k = 0; k <= 4; k++) @(negedge arduino_clk);
    checkAll("abort_pin2", 4, 2, 0, 1);
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge arduino_clk);
      checkAll($sformatf("abort%0d", k), 0, 0, 0, 0);
    end
    enable = 1'b1;
    @(negedge arduino_clk);
    checkAll("reenable", 1, 0, 0, 1);

    // Abort from a GAP cycle
    @(negedge arduino_clk);
    checkAll("gap_before_abort", 0, 0, 0, 1);
    enable = 1'b0;
    @(negedge arduino_clk);
    checkAll("gap_abort", 0, 0, 0, 0);

    // All masked, then unmask only pin 4
    doReset(1'b1, 1'b0, 1, 6'b111111);
    for (int k = 0; k < 8; k++) begin
      @(negedge arduino_clk);
      checkAll($sformatf("allmask%0d", k), 0, 0, 0, 0);
    end
    skip_mask = 6'b101111;
    for (int k = 0; k < 9; k++) begin
      @(negedge arduino_clk);
      checkAll($sformatf("pin4_%0d", k), (k % 3 != 2) ? 16 : 0, 4,
               (k % 3 == 2) ? 1 : 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
